// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
//   STG_F..STG_W : bit positions of each stage in the stall/flush vectors.
//   N_STG        : number of pipeline stages (width of stall/flush).
//   FWD_NONE     : forwarding select value meaning "take the register file".
package hazard_pkg;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;
  localparam int N_STG = 5;

  localparam int FWD_NONE = 0;

endpackage

// File: rtl/hazard_fwd_match.sv
// Per-operand forwarding priority matcher.
//   addr      : E-stage source register address of this operand.
//   use_op    : the E instruction really reads this operand.
//   fwd_we    : source k writes a register.
//   fwd_waddr : destination of source k, k=0 in the LSBs.
//   fwd_ready : source k's result is available this cycle.
//   sel       : 0 = register file, k+1 = youngest matching source k.
//   not_ready : the winning source has no data yet (dependency bubble needed).
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int N_FWD  = 3,
  parameter int REG_AW = 5,
  parameter int SELW   = $clog2(N_FWD + 1)
) (
  input  logic [REG_AW-1:0]       addr,
  input  logic                    use_op,
  input  logic [N_FWD-1:0]        fwd_we,
  input  logic [N_FWD*REG_AW-1:0] fwd_waddr,
  input  logic [N_FWD-1:0]        fwd_ready,
  output logic [SELW-1:0]         sel,
  output logic                    not_ready
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise the tool infers a latch.
  always_comb begin
    sel       = SELW'(FWD_NONE);
    not_ready = 1'b0;
    // Register 0 is hard-wired zero and unused operands carry garbage
    // addresses, so neither may match anything.
    if (use_op && (addr != '0)) begin
      // Scan oldest to youngest so the youngest (lowest k) match is written
      // last and wins.
      for (int k = N_FWD - 1; k >= 0; k--) begin
        if (fwd_we[k] && (fwd_waddr[k*REG_AW +: REG_AW] == addr)) begin
          sel       = SELW'(k + 1);
          not_ready = ~fwd_ready[k];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit_param.sv
// Parametrised hazard controller for the five-stage F/D/E/M/W pipeline.
//   clk, rst              : clock, asynchronous active-high reset.
//   rs_e/rt_e, use_rs_e/use_rt_e : E-stage operand addresses and use flags.
//   fwd_we/fwd_waddr/fwd_ready   : forwarding sources, 0 = youngest (M).
//   i_cache_stall, d_cache_stall, div_stall_e, mult_stall_e : long stalls.
//   flush_jump_conflict_e, flush_pred_failed_m : one-cycle redirect events.
//   flush_exception_m     : exception flush, overrides everything.
//   clr_cnt               : synchronous clear of the performance counters.
//   stall, flush          : per-stage controls, bit 0 = F ... bit 4 = W.
//   fwd_sel_a, fwd_sel_b  : E-stage operand forwarding selects.
//   cnt_dep, cnt_long     : dependency-bubble / long-stall cycle counters.
module hazard_unit_param
  import hazard_pkg::*;
#(
  parameter int N_FWD  = 3,
  parameter int REG_AW = 5,
  parameter int SELW   = $clog2(N_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_AW-1:0]       rs_e,
  input  logic [REG_AW-1:0]       rt_e,
  input  logic                    use_rs_e,
  input  logic                    use_rt_e,
  input  logic [N_FWD-1:0]        fwd_we,
  input  logic [N_FWD*REG_AW-1:0] fwd_waddr,
  input  logic [N_FWD-1:0]        fwd_ready,
  input  logic                    i_cache_stall,
  input  logic                    d_cache_stall,
  input  logic                    div_stall_e,
  input  logic                    mult_stall_e,
  input  logic                    flush_jump_conflict_e,
  input  logic                    flush_pred_failed_m,
  input  logic                    flush_exception_m,
  input  logic                    clr_cnt,
  output logic [N_STG-1:0]        stall,
  output logic [N_STG-1:0]        flush,
  output logic [SELW-1:0]         fwd_sel_a,
  output logic [SELW-1:0]         fwd_sel_b,
  output logic [31:0]             cnt_dep,
  output logic [31:0]             cnt_long
);

  logic not_ready_a;
  logic not_ready_b;
  logic dep;
  logic long_stall;
  logic exc;
  logic pend_pred;
  logic pend_jump;
  logic eff_pred;
  logic eff_jump;

  hazard_fwd_match #(
    .N_FWD (N_FWD),
    .REG_AW(REG_AW),
    .SELW  (SELW)
  ) u_match_a (
    .addr     (rs_e),
    .use_op   (use_rs_e),
    .fwd_we   (fwd_we),
    .fwd_waddr(fwd_waddr),
    .fwd_ready(fwd_ready),
    .sel      (fwd_sel_a),
    .not_ready(not_ready_a)
  );

  hazard_fwd_match #(
    .N_FWD (N_FWD),
    .REG_AW(REG_AW),
    .SELW  (SELW)
  ) u_match_b (
    .addr     (rt_e),
    .use_op   (use_rt_e),
    .fwd_we   (fwd_we),
    .fwd_waddr(fwd_waddr),
    .fwd_ready(fwd_ready),
    .sel      (fwd_sel_b),
    .not_ready(not_ready_b)
  );

  assign dep        = not_ready_a | not_ready_b;
  assign long_stall = i_cache_stall | d_cache_stall | div_stall_e | mult_stall_e;
  assign exc        = flush_exception_m;

  // Redirects are single-cycle pulses; a pending bit keeps one alive until
  // the pipeline is free to act on it.
  assign eff_pred = flush_pred_failed_m | pend_pred;
  assign eff_jump = flush_jump_conflict_e | pend_jump;

  always_comb begin
    stall = '0;
    flush = '0;

    // F keeps fetching the handler when an exception redirects it.
    stall[STG_F] = ~exc & (long_stall | dep);
    stall[STG_D] = long_stall | dep;
    stall[STG_E] = long_stall | dep;
    stall[STG_M] = long_stall;
    stall[STG_W] = long_stall;

    flush[STG_D] = exc | (eff_pred & ~long_stall) | (eff_jump & ~long_stall & ~dep);
    flush[STG_E] = exc | (eff_pred & ~long_stall);
    // A dependency holds E in place; M gets a bubble instead of a duplicate.
    flush[STG_M] = exc | (dep & ~long_stall);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_pred <= 1'b0;
      pend_jump <= 1'b0;
    end else begin
      pend_pred <= ~exc & eff_pred & long_stall;
      // A prediction flush kills E, which makes any jump conflict moot.
      pend_jump <= ~exc & ~eff_pred & eff_jump & (long_stall | dep);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_dep  <= '0;
      cnt_long <= '0;
    end else if (clr_cnt) begin
      cnt_dep  <= '0;
      cnt_long <= '0;
    end else begin
      if (dep && !long_stall) cnt_dep <= cnt_dep + 32'd1;
      if (long_stall)         cnt_long <= cnt_long + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Scoreboard bench for hazard_unit_param: stimulus pushes the reference
// model's expectation per cycle, a negedge monitor pops and compares.
module tb_hazard_unit_param;

  localparam int N_FWD  = 3;
  localparam int REG_AW = 5;
  localparam int SELW   = $clog2(N_FWD + 1);

  logic                    clk;
  logic                    rst;
  logic [REG_AW-1:0]       rs_e, rt_e;
  logic                    use_rs_e, use_rt_e;
  logic [N_FWD-1:0]        fwd_we;
  logic [N_FWD*REG_AW-1:0] fwd_waddr;
  logic [N_FWD-1:0]        fwd_ready;
  logic                    i_cache_stall, d_cache_stall, div_stall_e, mult_stall_e;
  logic                    flush_jump_conflict_e, flush_pred_failed_m, flush_exception_m;
  logic                    clr_cnt;
  logic [4:0]              stall, flush;
  logic [SELW-1:0]         fwd_sel_a, fwd_sel_b;
  logic [31:0]             cnt_dep, cnt_long;

  logic [REG_AW-1:0]       t_waddr [N_FWD];

  typedef struct {
    logic [4:0]      stall;
    logic [4:0]      flush;
    logic [SELW-1:0] sel_a;
    logic [SELW-1:0] sel_b;
    logic [31:0]     cd;
    logic [31:0]     cl;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: held redirects and counter values.
  bit          m_held_pred, m_held_jump;
  int unsigned m_cd, m_cl;

  hazard_unit_param #(
    .N_FWD (N_FWD),
    .REG_AW(REG_AW),
    .SELW  (SELW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rs_e                 (rs_e),
    .rt_e                 (rt_e),
    .use_rs_e             (use_rs_e),
    .use_rt_e             (use_rt_e),
    .fwd_we               (fwd_we),
    .fwd_waddr            (fwd_waddr),
    .fwd_ready            (fwd_ready),
    .i_cache_stall        (i_cache_stall),
    .d_cache_stall        (d_cache_stall),
    .div_stall_e          (div_stall_e),
    .mult_stall_e         (mult_stall_e),
    .flush_jump_conflict_e(flush_jump_conflict_e),
    .flush_pred_failed_m  (flush_pred_failed_m),
    .flush_exception_m    (flush_exception_m),
    .clr_cnt              (clr_cnt),
    .stall                (stall),
    .flush                (flush),
    .fwd_sel_a            (fwd_sel_a),
    .fwd_sel_b            (fwd_sel_b),
    .cnt_dep              (cnt_dep),
    .cnt_long             (cnt_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest source writing the operand's register, or -1 if none applies.
  function automatic int winner(input logic [REG_AW-1:0] a, input logic u);
    if (!u || a == 0) return -1;
    for (int k = 0; k < N_FWD; k++)
      if (fwd_we[k] && t_waddr[k] == a) return k;
    return -1;
  endfunction

  task automatic model_and_push();
    exp_t e;
    int   wa, wb;
    bit   dep, lng, exc, pred, jump, bubble, frz;
    if (rst) begin
      m_held_pred = 0; m_held_jump = 0; m_cd = 0; m_cl = 0;
    end
    wa   = winner(rs_e, use_rs_e);
    wb   = winner(rt_e, use_rt_e);
    dep  = (wa >= 0 && !fwd_ready[wa]) || (wb >= 0 && !fwd_ready[wb]);
    lng  = i_cache_stall || d_cache_stall || div_stall_e || mult_stall_e;
    exc  = flush_exception_m;
    pred = flush_pred_failed_m || m_held_pred;
    jump = flush_jump_conflict_e || m_held_jump;
    frz  = lng || dep;
    // Stall vector: W,M,E,D,F
    e.stall = {lng, lng, frz, frz, frz && !exc};
    bubble  = dep && !lng;
    e.flush = {1'b0,
               exc || bubble,
               exc || (pred && !lng),
               exc || (pred && !lng) || (jump && !frz),
               1'b0};
    e.sel_a = (wa < 0) ? '0 : SELW'(wa + 1);
    e.sel_b = (wb < 0) ? '0 : SELW'(wb + 1);
    e.cd    = m_cd;
    e.cl    = m_cl;
    q.push_back(e);
    if (!rst) begin
      m_held_pred = !exc && pred && lng;
      m_held_jump = !exc && !pred && jump && frz;
      if (clr_cnt) begin
        m_cd = 0; m_cl = 0;
      end else begin
        if (bubble) m_cd = m_cd + 1;
        if (lng)    m_cl = m_cl + 1;
      end
    end
  endtask

  task automatic idle();
    rs_e = '0; rt_e = '0; use_rs_e = 0; use_rt_e = 0;
    fwd_we = '0; fwd_ready = '0;
    for (int k = 0; k < N_FWD; k++) t_waddr[k] = '0;
    i_cache_stall = 0; d_cache_stall = 0; div_stall_e = 0; mult_stall_e = 0;
    flush_jump_conflict_e = 0; flush_pred_failed_m = 0; flush_exception_m = 0;
    clr_cnt = 0;
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic cyc_end();
    for (int k = 0; k < N_FWD; k++) fwd_waddr[k*REG_AW +: REG_AW] = t_waddr[k];
    model_and_push();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("stall",     32'(stall),     32'(e.stall));
      check("flush",     32'(flush),     32'(e.flush));
      check("fwd_sel_a", 32'(fwd_sel_a), 32'(e.sel_a));
      check("fwd_sel_b", 32'(fwd_sel_b), 32'(e.sel_b));
      check("cnt_dep",   cnt_dep,        e.cd);
      check("cnt_long",  cnt_long,       e.cl);
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    fwd_waddr = '0;
    cyc_begin(); cyc_end();
    @(negedge clk);
    check("reset_cnt_long", cnt_long, 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    cyc_begin(); rst = 1'b0; cyc_end();

    // Youngest of two matching sources wins; r0 never forwards.
    cyc_begin();
    use_rs_e = 1; rs_e = 5; fwd_we = 3'b101; t_waddr[0] = 5; t_waddr[2] = 5; fwd_ready = 3'b111;
    cyc_end();
    @(negedge clk) check("dir_sel_a_youngest", 32'(fwd_sel_a), 32'd1);
    cyc_begin();
    use_rs_e = 1; rs_e = 0; fwd_we = 3'b101; t_waddr[0] = 0; t_waddr[2] = 0; fwd_ready = 3'b111;
    cyc_end();
    @(negedge clk) check("dir_sel_a_r0", 32'(fwd_sel_a), 32'd0);

    // Load-use bubble, then forward from W.
    cyc_begin(); clr_cnt = 1; cyc_end();
    cyc_begin();
    use_rt_e = 1; rt_e = 8; fwd_we = 3'b001; t_waddr[0] = 8; fwd_ready = 3'b000;
    cyc_end();
    @(negedge clk);
    check("dir_load_stall", 32'(stall), 32'b00111);
    check("dir_load_flush", 32'(flush), 32'b01000);
    cyc_begin();
    use_rt_e = 1; rt_e = 8; fwd_we = 3'b100; t_waddr[2] = 8; fwd_ready = 3'b100;
    cyc_end();
    @(negedge clk);
    check("dir_sel_b_w", 32'(fwd_sel_b), 32'd3);
    check("dir_nostall", 32'(stall), 32'd0);
    check("dir_cnt_dep", cnt_dep, 32'd1);

    // Unused operand never stalls.
    cyc_begin();
    use_rt_e = 0; rt_e = 8; fwd_we = 3'b001; t_waddr[0] = 8;
    cyc_end();
    @(negedge clk);
    check("dir_unused_stall", 32'(stall), 32'd0);
    check("dir_unused_sel", 32'(fwd_sel_b), 32'd0);

    // Prediction flush held across a 4-cycle D-cache stall.
    cyc_begin(); clr_cnt = 1; cyc_end();
    for (int c = 1; c <= 4; c++) begin
      cyc_begin();
      d_cache_stall = 1;
      flush_pred_failed_m = (c == 1);
      cyc_end();
      @(negedge clk) check("dir_pred_held", 32'(flush[2:1]), 32'd0);
    end
    cyc_begin(); cyc_end();
    @(negedge clk);
    check("dir_pred_apply", 32'(flush), 32'b00110);
    check("dir_cnt_long", cnt_long, 32'd4);
    cyc_begin(); cyc_end();
    @(negedge clk) check("dir_pred_once", 32'(flush), 32'd0);

    // Held jump killed by an exception.
    cyc_begin(); div_stall_e = 1; flush_jump_conflict_e = 1; cyc_end();
    @(negedge clk) check("dir_jump_held", 32'(flush), 32'd0);
    cyc_begin(); div_stall_e = 1; flush_exception_m = 1; cyc_end();
    @(negedge clk);
    check("dir_exc_flush", 32'(flush), 32'b01110);
    check("dir_exc_stall", 32'(stall), 32'b11110);
    cyc_begin(); cyc_end();
    @(negedge clk) check("dir_jump_dropped", 32'(flush), 32'd0);

    // Reset mid-stall discards a held prediction flush and the counters.
    cyc_begin(); mult_stall_e = 1; flush_pred_failed_m = 1; cyc_end();
    cyc_begin(); rst = 1; mult_stall_e = 1; cyc_end();
    @(negedge clk);
    check("dir_rst_cnt_long", cnt_long, 32'd0);
    check("dir_rst_cnt_dep", cnt_dep, 32'd0);
    cyc_begin(); rst = 0; cyc_end();
    @(negedge clk);
    check("dir_rst_noflush", 32'(flush), 32'd0);
    check("dir_rst_cnt_after", cnt_long, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      cyc_begin();
      rst       = ($urandom_range(0, 199) == 0);
      rs_e      = REG_AW'($urandom_range(0, 7));
      rt_e      = REG_AW'($urandom_range(0, 7));
      use_rs_e  = 1'($urandom);
      use_rt_e  = 1'($urandom);
      fwd_we    = N_FWD'($urandom);
      fwd_ready = N_FWD'($urandom);
      for (int k = 0; k < N_FWD; k++) t_waddr[k] = REG_AW'($urandom_range(0, 7));
      i_cache_stall         = ($urandom_range(0, 15) == 0);
      d_cache_stall         = ($urandom_range(0, 15) == 0);
      div_stall_e           = ($urandom_range(0, 15) == 0);
      mult_stall_e          = ($urandom_range(0, 15) == 0);
      flush_jump_conflict_e = ($urandom_range(0, 5) == 0);
      flush_pred_failed_m   = ($urandom_range(0, 5) == 0);
      flush_exception_m     = ($urandom_range(0, 15) == 0);
      clr_cnt               = ($urandom_range(0, 49) == 0);
      cyc_end();
    end
    cyc_begin(); rst = 0; cyc_end();

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
